bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Bus arbiter: lends the CPU-owned system bus to the PRC or DMA master, round-robin.
// Define BUS_ARBITER_WATCHDOG_EN to bound each grant to HOLD_LIMIT cycles (sticky timeout).
module bus_arbiter #(
    parameter int unsigned HOLD_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        prc_req,
    output logic        prc_ack,
    input  logic        dma_req,
    output logic        dma_ack,
    output logic        cpu_bus_request,
    input  logic        cpu_bus_ack,

    input  logic [23:0] cpu_address_in,
    input  logic [23:0] prc_address_in,
    input  logic [23:0] dma_address_in,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  prc_data_in,
    input  logic [7:0]  dma_data_in,
    input  logic        cpu_read,
    input  logic        prc_read,
    input  logic        dma_read,
    input  logic        cpu_write,
    input  logic        prc_write,
    input  logic        dma_write,
    input  logic [1:0]  cpu_bus_status,
    input  logic [1:0]  prc_bus_status,
    input  logic [1:0]  dma_bus_status,

    output logic [23:0] address_out,
    output logic [7:0]  data_out,
    output logic        read,
    output logic        write,
    output logic [1:0]  bus_status,
    output logic        timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ_CPU = 2'd1;
    localparam logic [1:0] GRANT   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Why the bus is in RELEASE; decides where it goes next.
    localparam logic [1:0] REL_NORMAL = 2'd0;
    localparam logic [1:0] REL_LOST   = 2'd1;
    localparam logic [1:0] REL_NONE   = 2'd2;

    localparam logic SEL_PRC = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    logic [1:0]  state_q, state_d;
    logic [1:0]  why_q, why_d;
    logic        cur_q, cur_d;
    logic        last_grant_q, last_grant_d;
    logic [23:0] addr_hold_q;
    logic [7:0]  data_hold_q;

    logic        prc_ok, dma_ok, any_ok, pick, cur_req, revoke;
    logic [23:0] g_addr;
    logic [7:0]  g_data;
    logic        g_read, g_write;
    logic [1:0]  g_status;

`ifdef BUS_ARBITER_WATCHDOG_EN
    localparam int unsigned CW = $clog2(HOLD_LIMIT + 1);

    logic [CW-1:0] hold_q;
    logic          timeout_q, prc_blk_q, dma_blk_q;

    assign revoke  = (state_q == GRANT) && (hold_q == CW'(HOLD_LIMIT - 1));
    assign prc_ok  = prc_req & ~prc_blk_q;
    assign dma_ok  = dma_req & ~dma_blk_q;
    assign timeout = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
            prc_blk_q <= 1'b0;
            dma_blk_q <= 1'b0;
        end else begin
            hold_q    <= (state_q == GRANT && state_d == GRANT) ? hold_q + 1'b1 : '0;
            timeout_q <= timeout_q | revoke;
            // A revoked master stays locked out until its request is seen low.
            prc_blk_q <= (prc_blk_q & prc_req) | (revoke & (cur_q == SEL_PRC));
            dma_blk_q <= (dma_blk_q & dma_req) | (revoke & (cur_q == SEL_DMA));
        end
    end
`else
    assign revoke  = 1'b0;
    assign prc_ok  = prc_req;
    assign dma_ok  = dma_req;
    assign timeout = 1'b0;
`endif

    assign any_ok  = prc_ok | dma_ok;
    assign pick    = (prc_ok & dma_ok) ? ~last_grant_q : dma_ok;
    assign cur_req = (cur_q == SEL_DMA) ? dma_req : prc_req;

    always_comb begin
        state_d      = state_q;
        why_d        = why_q;
        cur_d        = cur_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_ok) state_d = REQ_CPU;
            end
            REQ_CPU: begin
                if (cpu_bus_ack) begin
                    if (any_ok) begin
                        state_d      = GRANT;
                        cur_d        = pick;
                        last_grant_d = pick;
                    end else begin
                        state_d = RELEASE;
                        why_d   = REL_NONE;
                    end
                end
            end
            GRANT: begin
                if (!cpu_bus_ack || !cur_req || revoke) begin
                    state_d = RELEASE;
                    why_d   = cpu_bus_ack ? REL_NORMAL : REL_LOST;
                end
            end
            RELEASE: begin
                if (why_q == REL_LOST) begin
                    state_d = any_ok ? REQ_CPU : IDLE;
                end else if (why_q == REL_NORMAL && cpu_bus_ack &&
                             ((cur_q == SEL_PRC) ? dma_ok : prc_ok)) begin
                    state_d      = GRANT;
                    cur_d        = ~cur_q;
                    last_grant_d = ~cur_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            why_q        <= REL_NONE;
            cur_q        <= SEL_PRC;
            last_grant_q <= SEL_DMA;
            addr_hold_q  <= '0;
            data_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            why_q        <= why_d;
            cur_q        <= cur_d;
            last_grant_q <= last_grant_d;
            if (state_q == GRANT) begin
                addr_hold_q <= g_addr;
                data_hold_q <= g_data;
            end
        end
    end

    always_comb begin
        if (cur_q == SEL_DMA) begin
            g_addr   = dma_address_in;
            g_data   = dma_data_in;
            g_read   = dma_read;
            g_write  = dma_write;
            g_status = dma_bus_status;
        end else begin
            g_addr   = prc_address_in;
            g_data   = prc_data_in;
            g_read   = prc_read;
            g_write  = prc_write;
            g_status = prc_bus_status;
        end
    end

    assign prc_ack         = (state_q == GRANT) && (cur_q == SEL_PRC);
    assign dma_ack         = (state_q == GRANT) && (cur_q == SEL_DMA);
    assign cpu_bus_request = (state_q != IDLE);

    always_comb begin
        address_out = cpu_address_in;
        data_out    = cpu_data_in;
        read        = cpu_read;
        write       = cpu_write;
        bus_status  = cpu_bus_status;
        if (state_q == GRANT) begin
            address_out = g_addr;
            data_out    = g_data;
            read        = g_read;
            write       = g_write;
            bus_status  = g_status;
        end else if (state_q == RELEASE) begin
            address_out = addr_hold_q;
            data_out    = data_hold_q;
            read        = 1'b0;
            write       = 1'b0;
            bus_status  = 2'b00;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model of bus ownership.
module tb_bus_arbiter;

    localparam int unsigned HL = 8;
    localparam int WHY_DONE = 0;
    localparam int WHY_LOST = 1;
    localparam int WHY_NONE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prc_req = 1'b0, dma_req = 1'b0, cpu_bus_ack = 1'b0;
    logic        prc_ack, dma_ack, cpu_bus_request, timeout;
    logic [23:0] cpu_address_in = '0, prc_address_in = '0, dma_address_in = '0, address_out;
    logic [7:0]  cpu_data_in = '0, prc_data_in = '0, dma_data_in = '0, data_out;
    logic        cpu_read = 1'b0, prc_read = 1'b0, dma_read = 1'b0, read;
    logic        cpu_write = 1'b0, prc_write = 1'b0, dma_write = 1'b0, write;
    logic [1:0]  cpu_bus_status = '0, prc_bus_status = '0, dma_bus_status = '0, bus_status;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus (-1 = CPU), whether the CPU has been asked, and the
    // one-cycle hand-back gap with the reason it happened.
    int          m_owner, m_last, m_prev, m_why, m_hold;
    bit          m_asking, m_gap, m_to;
    bit          m_blk [2];
    logic [23:0] m_addr;
    logic [7:0]  m_data;

    bus_arbiter #(.HOLD_LIMIT(HL)) dut (
        .clk(clk), .reset(reset),
        .prc_req(prc_req), .prc_ack(prc_ack), .dma_req(dma_req), .dma_ack(dma_ack),
        .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
        .cpu_address_in(cpu_address_in), .prc_address_in(prc_address_in),
        .dma_address_in(dma_address_in),
        .cpu_data_in(cpu_data_in), .prc_data_in(prc_data_in), .dma_data_in(dma_data_in),
        .cpu_read(cpu_read), .prc_read(prc_read), .dma_read(dma_read),
        .cpu_write(cpu_write), .prc_write(prc_write), .dma_write(dma_write),
        .cpu_bus_status(cpu_bus_status), .prc_bus_status(prc_bus_status),
        .dma_bus_status(dma_bus_status),
        .address_out(address_out), .data_out(data_out), .read(read), .write(write),
        .bus_status(bus_status), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_prev = 0; m_why = WHY_NONE; m_hold = 0;
        m_asking = 0; m_gap = 0; m_to = 0;
        m_blk[0] = 0; m_blk[1] = 0;
        m_addr = '0; m_data = '0;
    endtask

    // Advance the model by one clock edge using the inputs as sampled at that edge.
    task automatic model_edge();
        bit ep, ed, revoke, oreq;
        ep = prc_req && !m_blk[0];
        ed = dma_req && !m_blk[1];
        revoke = 0;
        if (!m_asking) begin
            if (ep || ed) m_asking = 1;
        end else if (m_gap) begin
            m_gap = 0;
            if (m_why == WHY_LOST) begin
                m_asking = ep || ed;
            end else if (m_why == WHY_DONE && cpu_bus_ack && ((m_prev == 0) ? ed : ep)) begin
                m_owner = 1 - m_prev; m_last = m_owner; m_hold = 0;
            end else begin
                m_asking = 0;
            end
        end else if (m_owner < 0) begin
            if (cpu_bus_ack) begin
                if (ep || ed) begin
                    m_owner = (ep && ed) ? 1 - m_last : (ep ? 0 : 1);
                    m_last = m_owner; m_hold = 0;
                end else begin
                    m_gap = 1; m_why = WHY_NONE;
                end
            end
        end else begin
            m_hold++;
`ifdef BUS_ARBITER_WATCHDOG_EN
            revoke = (m_hold >= int'(HL));
`endif
            m_addr = (m_owner == 0) ? prc_address_in : dma_address_in;
            m_data = (m_owner == 0) ? prc_data_in : dma_data_in;
            oreq = (m_owner == 0) ? prc_req : dma_req;
            if (!oreq || !cpu_bus_ack || revoke) begin
                m_prev = m_owner; m_owner = -1; m_gap = 1;
                m_why = cpu_bus_ack ? WHY_DONE : WHY_LOST;
                if (revoke) m_to = 1;
            end
        end
        m_blk[0] = (m_blk[0] && prc_req) || (revoke && m_prev == 0);
        m_blk[1] = (m_blk[1] && dma_req) || (revoke && m_prev == 1);
    endtask

    task automatic check_all(input string ph);
        logic [23:0] ea;
        logic [7:0]  edat;
        logic        er, ew;
        logic [1:0]  es;
        if (m_owner == 0)
            {ea, edat, er, ew, es} = {prc_address_in, prc_data_in, prc_read, prc_write, prc_bus_status};
        else if (m_owner == 1)
            {ea, edat, er, ew, es} = {dma_address_in, dma_data_in, dma_read, dma_write, dma_bus_status};
        else if (m_gap)
            {ea, edat, er, ew, es} = {m_addr, m_data, 1'b0, 1'b0, 2'b00};
        else
            {ea, edat, er, ew, es} = {cpu_address_in, cpu_data_in, cpu_read, cpu_write, cpu_bus_status};
        chk({ph, ".prc_ack"}, 32'(prc_ack), 32'(m_owner == 0));
        chk({ph, ".dma_ack"}, 32'(dma_ack), 32'(m_owner == 1));
        chk({ph, ".cpu_bus_request"}, 32'(cpu_bus_request), 32'(m_asking));
        chk({ph, ".timeout"}, 32'(timeout), 32'(m_to));
        chk({ph, ".address_out"}, 32'(address_out), 32'(ea));
        chk({ph, ".data_out"}, 32'(data_out), 32'(edat));
        chk({ph, ".read"}, 32'(read), 32'(er));
        chk({ph, ".write"}, 32'(write), 32'(ew));
        chk({ph, ".bus_status"}, 32'(bus_status), 32'(es));
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic do_reset();
        prc_req = 1'b0; dma_req = 1'b0; cpu_bus_ack = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset_rel");
    endtask

    task automatic rand_bus();
        cpu_address_in = 24'($urandom); prc_address_in = 24'($urandom);
        dma_address_in = 24'($urandom);
        cpu_data_in = 8'($urandom); prc_data_in = 8'($urandom); dma_data_in = 8'($urandom);
        {cpu_read, prc_read, dma_read, cpu_write, prc_write, dma_write} = 6'($urandom);
        cpu_bus_status = 2'($urandom); prc_bus_status = 2'($urandom);
        dma_bus_status = 2'($urandom);
    endtask

    initial begin
        int n;
        cpu_address_in = 24'hC0FFEE; prc_address_in = 24'h123456; dma_address_in = 24'hABCDEF;
        cpu_data_in = 8'h11; prc_data_in = 8'h22; dma_data_in = 8'h33;
        cpu_read = 1'b1; prc_read = 1'b1; dma_read = 1'b1;
        cpu_bus_status = 2'b01; prc_bus_status = 2'b10; dma_bus_status = 2'b11;

        // CPU handshake latency for a lone PRC request.
        do_reset();
        chk("r34.req_after_reset", 32'(cpu_bus_request), 32'd0);
        prc_req = 1'b1;
        cycle("r34.c1");
        chk("r34.cpu_req_c1", 32'(cpu_bus_request), 32'd1);
        cycle("r34.c2");
        cycle("r34.c3");
        chk("r34.no_ack_c3", 32'(prc_ack), 32'd0);
        cpu_bus_ack = 1'b1;
        cycle("r34.c4");
        chk("r34.prc_ack_c4", 32'(prc_ack), 32'd1);
        chk("r34.addr_c4", 32'(address_out), 32'h123456);

        // Tie after reset goes to PRC, then DMA after one release cycle.
        do_reset();
        cpu_bus_ack = 1'b1; prc_req = 1'b1; dma_req = 1'b1;
        cycle("r35.ask");
        cycle("r35.grant");
        chk("r35.prc_first", 32'(prc_ack), 32'd1);
        chk("r35.dma_wait", 32'(dma_ack), 32'd0);
        cycle("r35.hold");
        prc_req = 1'b0;
        cycle("r35.release");
        chk("r35.rel_read", 32'(read), 32'd0);
        chk("r35.rel_status", 32'(bus_status), 32'd0);
        chk("r35.rel_addr", 32'(address_out), 32'h123456);
        chk("r35.rel_cpu_req", 32'(cpu_bus_request), 32'd1);
        cycle("r35.dma");
        chk("r35.dma_ack", 32'(dma_ack), 32'd1);
        chk("r35.dma_addr", 32'(address_out), 32'hABCDEF);
        chk("r35.dma_cpu_req", 32'(cpu_bus_request), 32'd1);

        // Request withdrawn before the CPU answers.
        do_reset();
        dma_req = 1'b1;
        cycle("r36.ask");
        dma_req = 1'b0;
        cycle("r36.wait");
        cpu_bus_ack = 1'b1;
        cycle("r36.release");
        chk("r36.rel_no_ack", 32'(dma_ack), 32'd0);
        chk("r36.rel_cpu_req", 32'(cpu_bus_request), 32'd1);
        cycle("r36.idle");
        chk("r36.idle_cpu_req", 32'(cpu_bus_request), 32'd0);
        chk("r36.idle_addr", 32'(address_out), 32'hC0FFEE);

        // CPU takes the bus back mid-grant, then re-acks.
        do_reset();
        cpu_bus_ack = 1'b1; prc_req = 1'b1;
        cycle("r37.ask");
        cycle("r37.grant");
        cpu_bus_ack = 1'b0;
        cycle("r37.lost");
        chk("r37.ack_dropped", 32'(prc_ack), 32'd0);
        cycle("r37.reask");
        chk("r37.reask_req", 32'(cpu_bus_request), 32'd1);
        cpu_bus_ack = 1'b1;
        cycle("r37.regrant");
        chk("r37.regranted", 32'(prc_ack), 32'd1);

        // Grant length: bounded by the watchdog, otherwise unbounded.
        do_reset();
        cpu_bus_ack = 1'b1; dma_req = 1'b1;
        cycle("hold.ask");
        cycle("hold.grant");
`ifdef BUS_ARBITER_WATCHDOG_EN
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (dma_ack !== 1'b1) break;
            n++;
            cycle("r38.run");
        end
        chk("r38.hold_cycles", 32'(n), 32'd8);
        chk("r38.timeout", 32'(timeout), 32'd1);
        repeat (6) cycle("r38.locked");
        chk("r38.no_regrant", 32'(dma_ack), 32'd0);
        dma_req = 1'b0;
        cycle("r38.low");
        dma_req = 1'b1;
        cycle("r38.ask");
        cycle("r38.regrant");
        chk("r38.regranted", 32'(dma_ack), 32'd1);
        chk("r38.timeout_sticky", 32'(timeout), 32'd1);
`else
        n = 0;
        repeat (20) cycle("hold.run");
        chk("hold.unbounded", 32'(dma_ack), 32'd1);
        chk("hold.timeout_tied", 32'(timeout), 32'd0);
`endif

        // Asynchronous reset in the middle of a grant.
        do_reset();
        cpu_bus_ack = 1'b1; prc_req = 1'b1;
        cycle("r39.ask");
        cycle("r39.grant");
        #2;
        reset = 1'b1;
        #1;
        chk("r39.prc_ack", 32'(prc_ack), 32'd0);
        chk("r39.addr_cpu", 32'(address_out), 32'hC0FFEE);
        chk("r39.status_cpu", 32'(bus_status), 32'd1);
        chk("r39.cpu_req", 32'(cpu_bus_request), 32'd0);
        model_reset();
        prc_req = 1'b0;
        #1;
        reset = 1'b0;

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) prc_req = ~prc_req;
            if ($urandom_range(0, 5) == 0) dma_req = ~dma_req;
            cpu_bus_ack = ($urandom_range(0, 7) != 0);
            rand_bus();
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
